// File: rtl/crossbar_la_sequencer_if.sv
// LA command/handshake and crossbar drive signals of crossbar_la_sequencer.
// slave = sequencer side, master = firmware/LA and crossbar side.
interface crossbar_la_sequencer_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int PW_W = 8
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic             cmd_toggle;
    logic [1:0]       cmd_op;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic [PW_W-1:0]  cmd_pw;
    logic             sa_in;
    logic [ROWS-1:0]  row_sel;
    logic [COLS-1:0]  col_sel;
    logic             wl_pulse;
    logic             set_mode;
    logic             rd_en;
    logic             rd_data;
    logic             busy;
    logic             done_toggle;
    logic             err;
    logic             ovr;

    modport slave (
        input  cmd_toggle, cmd_op, cmd_row, cmd_col, cmd_pw, sa_in,
        output row_sel, col_sel, wl_pulse, set_mode, rd_en, rd_data,
               busy, done_toggle, err, ovr
    );

    modport master (
        output cmd_toggle, cmd_op, cmd_row, cmd_col, cmd_pw, sa_in,
        input  row_sel, col_sel, wl_pulse, set_mode, rd_en, rd_data,
               busy, done_toggle, err, ovr
    );
endinterface

// File: rtl/crossbar_la_sequencer.sv
// ReRAM crossbar command sequencer driven by an LA toggle handshake.
// Optional write-verify read-back enabled by defining CROSSBAR_SEQ_VERIFY_EN.
module crossbar_la_sequencer #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int PW_W      = 8,
    parameter int RD_SETTLE = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  resetb,
    crossbar_la_sequencer_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int RS_W  = $clog2(RD_SETTLE + 1);
    localparam int CNT_W = (PW_W > RS_W) ? PW_W : RS_W;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RD_SETTLE - 1);
    localparam logic [ROWS-1:0]  ROW_ONE     = ROWS'(1);
    localparam logic [COLS-1:0]  COL_ONE     = COLS'(1);
    localparam logic [31:0]      ROWS_U      = 32'(ROWS);
    localparam logic [31:0]      COLS_U      = 32'(COLS);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_RESET = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SENSE  = 3'd4,
        ST_VERIFY = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             sync1_r, sync2_r, sync_prev_r, ref_r, ref_nxt_s;
    logic [1:0]       op_r, op_nxt_s;
    logic [ROW_W-1:0] row_r, row_nxt_s;
    logic [COL_W-1:0] col_r, col_nxt_s;
    logic [PW_W-1:0]  pw_r, pw_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             accept_s, bad_cmd_s, sample_s, verify_s;
    logic             pending_s, addr_ok_s, is_write_s, sel_on_s;

    logic [ROWS-1:0]  row_sel_r;
    logic [COLS-1:0]  col_sel_r;
    logic             wl_pulse_r, set_mode_r, rd_en_r, rd_data_r;
    logic             busy_r, done_toggle_r, err_r, ovr_r;

    assign pending_s  = sync2_r ^ ref_r;
    assign addr_ok_s  = (32'(bus.cmd_row) < ROWS_U) && (32'(bus.cmd_col) < COLS_U);
    assign is_write_s = (bus.cmd_op == OP_SET) || (bus.cmd_op == OP_RESET);
    assign sel_on_s   = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_PULSE) ||
                        (state_nxt_s == ST_HOLD)  || (state_nxt_s == ST_SENSE) ||
                        (state_nxt_s == ST_VERIFY);

    // Next-state, command capture and counter control.
    always_comb begin
        state_nxt_s = state_r;
        ref_nxt_s   = ref_r;
        op_nxt_s    = op_r;
        row_nxt_s   = row_r;
        col_nxt_s   = col_r;
        pw_nxt_s    = pw_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        bad_cmd_s   = 1'b0;
        sample_s    = 1'b0;
        verify_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pending_s) begin
                    accept_s  = 1'b1;
                    ref_nxt_s = sync2_r;
                    op_nxt_s  = bus.cmd_op;
                    row_nxt_s = bus.cmd_row;
                    col_nxt_s = bus.cmd_col;
                    pw_nxt_s  = bus.cmd_pw;
                    if (bus.cmd_op == OP_NOP) begin
                        state_nxt_s = ST_DONE;
                    end else if (!addr_ok_s || (is_write_s && (bus.cmd_pw == PW_W'(0)))) begin
                        state_nxt_s = ST_DONE;
                        bad_cmd_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_SETUP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (op_r == OP_READ) begin
                    state_nxt_s = ST_SENSE;
                    cnt_nxt_s   = SETTLE_LAST;
                end else begin
                    state_nxt_s = ST_PULSE;
                    cnt_nxt_s   = CNT_W'(pw_r) - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_HOLD: begin
`ifdef CROSSBAR_SEQ_VERIFY_EN
                state_nxt_s = ST_VERIFY;
                cnt_nxt_s   = SETTLE_LAST;
`else
                state_nxt_s = ST_DONE;
`endif
            end
            ST_SENSE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                    sample_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_VERIFY: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                    sample_s    = 1'b1;
                    verify_s    = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Two-flop toggle synchronizer plus previous value for overrun detection.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            sync_prev_r <= 1'b0;
        end else begin
            sync1_r     <= bus.cmd_toggle;
            sync2_r     <= sync1_r;
            sync_prev_r <= sync2_r;
        end
    end

    // FSM state, reference bit and captured command.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
            ref_r   <= 1'b0;
            op_r    <= OP_NOP;
            row_r   <= '0;
            col_r   <= '0;
            pw_r    <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            ref_r   <= ref_nxt_s;
            op_r    <= op_nxt_s;
            row_r   <= row_nxt_s;
            col_r   <= col_nxt_s;
            pw_r    <= pw_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Crossbar drive outputs registered from the state being entered, so selects lead and trail the pulse.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            row_sel_r  <= '0;
            col_sel_r  <= '0;
            wl_pulse_r <= 1'b0;
            set_mode_r <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            row_sel_r  <= sel_on_s ? (ROW_ONE << row_nxt_s) : '0;
            col_sel_r  <= sel_on_s ? (COL_ONE << col_nxt_s) : '0;
            wl_pulse_r <= (state_nxt_s == ST_PULSE);
            set_mode_r <= sel_on_s && (state_nxt_s != ST_SENSE) && (op_nxt_s == OP_SET);
            rd_en_r    <= (state_nxt_s == ST_SENSE) || (state_nxt_s == ST_VERIFY);
        end
    end

    // Status: busy, completion toggle, read data, sticky err/ovr.
    always_ff @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            busy_r        <= 1'b0;
            done_toggle_r <= 1'b0;
            rd_data_r     <= 1'b0;
            err_r         <= 1'b0;
            ovr_r         <= 1'b0;
        end else begin
            if (accept_s) begin
                busy_r <= 1'b1;
                err_r  <= bad_cmd_s;
                ovr_r  <= 1'b0;
            end else begin
                if (state_r == ST_DONE) begin
                    busy_r        <= 1'b0;
                    done_toggle_r <= ~done_toggle_r;
                end
                if (verify_s && (bus.sa_in != (op_r == OP_SET))) begin
                    err_r <= 1'b1;
                end
                if (busy_r && (sync2_r != sync_prev_r)) begin
                    ovr_r <= 1'b1;
                end
            end
            if (sample_s) begin
                rd_data_r <= bus.sa_in;
            end
        end
    end

    assign bus.row_sel     = row_sel_r;
    assign bus.col_sel     = col_sel_r;
    assign bus.wl_pulse    = wl_pulse_r;
    assign bus.set_mode    = set_mode_r;
    assign bus.rd_en       = rd_en_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.busy        = busy_r;
    assign bus.done_toggle = done_toggle_r;
    assign bus.err         = err_r;
    assign bus.ovr         = ovr_r;
endmodule

// File: tb/tb_crossbar_la_sequencer.sv
// Self-checking bench for crossbar_la_sequencer: cycle-by-cycle comparison against
// a schedule-based behavioural model, plus directed literal checks.
module tb_crossbar_la_sequencer;
    localparam int ROWS = 8, COLS = 8, PW_W = 8, RD_SETTLE = 4;
`ifdef CROSSBAR_SEQ_VERIFY_EN
    localparam int VERIFY_CYC = RD_SETTLE;
`else
    localparam int VERIFY_CYC = 0;
`endif

    logic wb_clk_i = 1'b0;
    logic resetb   = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    crossbar_la_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .PW_W(PW_W)) bus ();
    crossbar_la_sequencer #(.ROWS(ROWS), .COLS(COLS), .PW_W(PW_W), .RD_SETTLE(RD_SETTLE))
        dut (.wb_clk_i(wb_clk_i), .resetb(resetb), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // ---------------- behavioural model: per-cycle output schedule ----------------
    typedef struct packed {
        logic [ROWS-1:0] rs;
        logic [COLS-1:0] cs;
        logic wl, sm, rd, busy, flip, sample, vchk, vexp;
    } rec_t;

    rec_t sched[$];
    rec_t cur;
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_prev = 1'b0, m_ref = 1'b0;
    logic [ROWS-1:0] e_row = '0;
    logic [COLS-1:0] e_col = '0;
    logic e_wl = 1'b0, e_sm = 1'b0, e_rd = 1'b0, e_rdata = 1'b0;
    logic e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_ovr = 1'b0;
    logic ovr_hit;

    // Queue the outputs expected after each edge of one command; returns err-at-accept.
    function automatic logic build(input logic [1:0] op, input int row, input int col, input int pw);
        rec_t r;
        logic wr;
        wr = (op == 2'd1) || (op == 2'd2);
        r = '0;
        r.busy = 1'b1;
        if (op == 2'd0 || (wr && pw == 0) || row >= ROWS || col >= COLS) begin
            sched.push_back(r);
            r.busy = 1'b0; r.flip = 1'b1;
            sched.push_back(r);
            return (op != 2'd0);
        end
        r.rs[row] = 1'b1;
        r.cs[col] = 1'b1;
        r.sm = (op == 2'd1);
        sched.push_back(r);
        if (wr) begin
            r.wl = 1'b1;
            repeat (pw) sched.push_back(r);
            r.wl = 1'b0;
            sched.push_back(r);
            r.rd = 1'b1;
            repeat (VERIFY_CYC) sched.push_back(r);
            r = '0; r.busy = 1'b1;
            r.sample = (VERIFY_CYC != 0); r.vchk = (VERIFY_CYC != 0); r.vexp = (op == 2'd1);
            sched.push_back(r);
        end else begin
            r.sm = 1'b0; r.rd = 1'b1;
            repeat (RD_SETTLE) sched.push_back(r);
            r = '0; r.busy = 1'b1; r.sample = 1'b1;
            sched.push_back(r);
        end
        r = '0; r.flip = 1'b1;
        sched.push_back(r);
        return 1'b0;
    endfunction

    always @(posedge wb_clk_i or negedge resetb) begin
        if (!resetb) begin
            sched.delete();
            m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_ref = 1'b0;
            e_row = '0; e_col = '0; e_wl = 1'b0; e_sm = 1'b0; e_rd = 1'b0; e_rdata = 1'b0;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ovr = 1'b0;
        end else begin
            ovr_hit = e_busy && (m_s2 != m_prev);
            if (sched.size() == 0 && m_s2 != m_ref) begin
                m_ref = m_s2;
                e_ovr = 1'b0;
                e_err = build(bus.cmd_op, int'(bus.cmd_row), int'(bus.cmd_col), int'(bus.cmd_pw));
            end
            if (sched.size() != 0) begin
                cur = sched.pop_front();
                e_row = cur.rs; e_col = cur.cs; e_wl = cur.wl; e_sm = cur.sm;
                e_rd = cur.rd; e_busy = cur.busy;
                if (cur.sample) e_rdata = bus.sa_in;
                if (cur.vchk && (bus.sa_in != cur.vexp)) e_err = 1'b1;
                if (cur.flip) e_done = ~e_done;
            end
            if (ovr_hit) e_ovr = 1'b1;
            m_prev = m_s2; m_s2 = m_s1; m_s1 = bus.cmd_toggle;
        end
    end

    // Compare every cycle outside reset.
    always @(negedge wb_clk_i) begin
        if (resetb) begin
            chk("row_sel", 32'(bus.row_sel), 32'(e_row));
            chk("col_sel", 32'(bus.col_sel), 32'(e_col));
            chk("wl_pulse", 32'(bus.wl_pulse), 32'(e_wl));
            chk("set_mode", 32'(bus.set_mode), 32'(e_sm));
            chk("rd_en", 32'(bus.rd_en), 32'(e_rd));
            chk("rd_data", 32'(bus.rd_data), 32'(e_rdata));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done_toggle", 32'(bus.done_toggle), 32'(e_done));
            chk("err", 32'(bus.err), 32'(e_err));
            chk("ovr", 32'(bus.ovr), 32'(e_ovr));
        end
    end

    // ---------------- stimulus ----------------
    logic sa_rand = 1'b0, sa_fixed = 1'b0;
    initial begin
        bus.sa_in = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            bus.sa_in = sa_rand ? 1'($urandom) : sa_fixed;
        end
    end

    int r_acc, r_done, r_wl, r_rd;
    logic [ROWS-1:0] r_rs;
    logic [COLS-1:0] r_cs;
    logic r_sm, r_ovr;

    task automatic run_cmd(input logic [1:0] op, input int row, input int col, input int pw,
                           input int extra, input logic [1:0] q_op, input int q_row, input int q_col);
        int t0, ta, k;
        logic d0;
        @(negedge wb_clk_i);
        bus.cmd_op = op; bus.cmd_row = 3'(row); bus.cmd_col = 3'(col); bus.cmd_pw = 8'(pw);
        bus.cmd_toggle = ~bus.cmd_toggle;
        t0 = cyc; ta = cyc; d0 = bus.done_toggle;
        r_acc = -1; r_done = -1; r_wl = 0; r_rd = 0; r_rs = '0; r_cs = '0; r_sm = 1'b0; r_ovr = 1'b0;
        for (int i = 0; i < 600 && r_done < 0; i++) begin
            @(negedge wb_clk_i);
            if (r_acc < 0 && bus.busy) begin
                r_acc = cyc - t0; ta = cyc;
                bus.cmd_op = q_op; bus.cmd_row = 3'(q_row); bus.cmd_col = 3'(q_col);
            end
            if (r_acc >= 0) begin
                k = cyc - ta;
                if (extra > 0 && k >= 5 && ((k - 5) % 3) == 0 && (k - 5) / 3 < extra)
                    bus.cmd_toggle = ~bus.cmd_toggle;
            end
            if (bus.wl_pulse) begin r_wl++; r_sm = bus.set_mode; end
            if (bus.rd_en) r_rd++;
            if (bus.row_sel != '0) r_rs = bus.row_sel;
            if (bus.col_sel != '0) r_cs = bus.col_sel;
            if (bus.done_toggle != d0) begin r_done = cyc - ta; r_ovr = bus.ovr; end
        end
        chk("cmd_completes", 32'(r_done >= 0), 32'd1);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (n < 600 && !(sched.size() == 0 && m_s1 == m_ref && m_s2 == m_ref &&
                            bus.cmd_toggle == m_ref && !bus.busy)) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("quiet_timeout", 32'(n < 600), 32'd1);
    endtask

    int flips;
    logic dprev;

    initial begin
        bus.cmd_toggle = 1'b0; bus.cmd_op = 2'd0; bus.cmd_row = '0; bus.cmd_col = '0; bus.cmd_pw = '0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done_toggle), 32'd0);
        chk("rst_sel", 32'({bus.row_sel, bus.col_sel}), 32'd0);
        resetb = 1'b1;
        repeat (100) @(negedge wb_clk_i);
        chk("idle100_busy", 32'(bus.busy), 32'd0);

        // SET row 3 col 5 pw 10
        sa_fixed = 1'b1;
        run_cmd(2'd1, 3, 5, 10, 0, 2'd1, 3, 5);
        chk("set_acc_lat", 32'(r_acc), 32'd3);
        chk("set_done_lat", 32'(r_done), 32'(13 + VERIFY_CYC));
        chk("set_wl_cycles", 32'(r_wl), 32'd10);
        chk("set_row_sel", 32'(r_rs), 32'h08);
        chk("set_col_sel", 32'(r_cs), 32'h20);
        chk("set_mode_in_pulse", 32'(r_sm), 32'd1);
        chk("set_rd_cycles", 32'(r_rd), 32'(VERIFY_CYC));
        chk("set_err", 32'(bus.err), 32'd0);
        wait_quiet();

        // READ row 7 col 0 with sa_in=1
        run_cmd(2'd3, 7, 0, 0, 0, 2'd3, 7, 0);
        chk("rd_done_lat", 32'(r_done), 32'd6);
        chk("rd_en_cycles", 32'(r_rd), 32'd4);
        chk("rd_data", 32'(bus.rd_data), 32'd1);
        chk("rd_row_sel", 32'(r_rs), 32'h80);
        chk("rd_col_sel", 32'(r_cs), 32'h01);
        wait_quiet();

        // RESET with pw=0, then READ clears err
        run_cmd(2'd2, 2, 2, 0, 0, 2'd2, 2, 2);
        chk("pw0_done_lat", 32'(r_done), 32'd1);
        chk("pw0_sel", 32'({r_rs, r_cs}), 32'd0);
        chk("pw0_wl", 32'(r_wl), 32'd0);
        chk("pw0_err", 32'(bus.err), 32'd1);
        wait_quiet();
        sa_fixed = 1'b0;
        run_cmd(2'd3, 1, 1, 0, 0, 2'd3, 1, 1);
        chk("rd_clears_err", 32'(bus.err), 32'd0);
        chk("rd_data0", 32'(bus.rd_data), 32'd0);
        wait_quiet();

        // Overrun: even and odd toggle counts during a long SET
        for (int extra = 2; extra <= 3; extra++) begin
            sa_fixed = 1'b1;
            run_cmd(2'd1, 4, 6, 50, extra, 2'd3, 1, 2);
            chk("ovr_at_done", 32'(r_ovr), 32'd1);
            flips = 0; dprev = bus.done_toggle;
            repeat (40) begin
                @(negedge wb_clk_i);
                if (bus.done_toggle != dprev) flips++;
                dprev = bus.done_toggle;
            end
            chk("queued_cmds", 32'(flips), 32'(extra % 2));
            wait_quiet();
        end

        // Asynchronous reset during PULSE
        run_cmd(2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
        wait_quiet();
        @(negedge wb_clk_i);
        bus.cmd_op = 2'd1; bus.cmd_row = 3'd2; bus.cmd_col = 3'd3; bus.cmd_pw = 8'd20;
        bus.cmd_toggle = ~bus.cmd_toggle;
        repeat (8) @(negedge wb_clk_i);
        chk("pre_rst_wl", 32'(bus.wl_pulse), 32'd1);
        @(posedge wb_clk_i);
        #2;
        resetb = 1'b0;
        bus.cmd_toggle = 1'b0;
        #1;
        chk("arst_wl", 32'(bus.wl_pulse), 32'd0);
        chk("arst_sel", 32'({bus.row_sel, bus.col_sel}), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        resetb = 1'b1;
        repeat (5) @(negedge wb_clk_i);

`ifdef CROSSBAR_SEQ_VERIFY_EN
        sa_fixed = 1'b0;
        run_cmd(2'd1, 0, 1, 3, 0, 2'd1, 0, 1);
        chk("verify_err", 32'(bus.err), 32'd1);
        wait_quiet();
`endif

        // Randomized commands, some with extra toggles while busy
        sa_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    2'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            wait_quiet();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
